// File: rtl/result_fifo_if.sv
// result_fifo_if: handshake/data bundle between the wrapper controller
// (master) and the result FIFO (slave).
//   clr       master->slave  synchronous clear
//   wr_req    master->slave  push wr_data (single-cycle pulse)
//   wr_data   master->slave  result word
//   rd_req    master->slave  pop head entry (single-cycle pulse)
//   rd_data   slave->master  head entry, 0 when empty (FWFT)
//   empty     slave->master  count == 0
//   full      slave->master  count == DEPTH
//   count     slave->master  stored entries
//   overflow  slave->master  sticky dropped-write flag
//   underflow slave->master  sticky read-while-empty flag
interface result_fifo_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

  logic                  clr;
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wr_req, wr_data, rd_req,
    input  rd_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  clr, wr_req, wr_data, rd_req,
    output rd_data, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/result_fifo.sv
// result_fifo: first-word-fall-through result buffer.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  result_fifo_if.slave (clear, push/pop handshake, head data, status)
// The head entry appears on rd_data with no read latency; full/empty are
// decoded from a dedicated count register rather than pointer comparison.
module result_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8
) (
  input  logic         clk,
  input  logic         rst,
  result_fifo_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] OneCount  = (ADDR_WIDTH + 1)'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("result_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  assign w_full  = (r_count == FullCount);
  assign w_empty = (r_count == '0);

  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  // clr suppresses both so that nothing lands in memory on a clear cycle.
  assign w_wr_ok = bus.wr_req && (!w_full || bus.rd_req) && !bus.clr;
  assign w_rd_ok = bus.rd_req && !w_empty && !bus.clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + OneCount;
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - OneCount;
      end
      if (bus.wr_req && !w_wr_ok) r_overflow  <= 1'b1;
      if (bus.rd_req && w_empty)  r_underflow <= 1'b1;
    end
  end

  // Storage carries no reset; a push racing an asserted rst is invisible
  // because the pointers and count are forced back to zero.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  assign bus.rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_result_fifo.sv
module tb_result_fifo;
  localparam int unsigned Dw    = 16;
  localparam int unsigned Depth = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // Reference model: a queue of words plus the two sticky flags.
  logic [Dw-1:0] model_q[$];
  bit            m_ovf;
  bit            m_unf;

  result_fifo_if #(.DATA_WIDTH(Dw), .DEPTH(Depth)) bus ();

  result_fifo #(.DATA_WIDTH(Dw), .DEPTH(Depth)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [Dw-1:0] exp_head;
    exp_head = (model_q.size() != 0) ? model_q[0] : '0;
    chk({tag, ".count"}, 32'(bus.count), 32'(model_q.size()));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(model_q.size() == Depth));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(bus.underflow), 32'(m_unf));
    chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(exp_head));
  endtask

  task automatic model_reset();
    model_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock: drive inputs, apply spec rules to the model, check after the edge.
  task automatic cyc(input bit clr, input bit wr, input bit rd, input logic [Dw-1:0] d,
                     input string tag);
    bit was_full;
    bit was_empty;
    bus.clr     = clr;
    bus.wr_req  = wr;
    bus.rd_req  = rd;
    bus.wr_data = d;
    was_full  = (model_q.size() == Depth);
    was_empty = (model_q.size() == 0);
    if (clr) begin
      model_reset();
    end else begin
      if (rd && !was_empty) void'(model_q.pop_front());
      if (rd && was_empty) m_unf = 1'b1;
      if (wr && (!was_full || rd)) model_q.push_back(d);
      else if (wr) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.clr    = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    chk_all(tag);
  endtask

  task automatic push(input logic [Dw-1:0] d, input string tag);
    cyc(1'b0, 1'b1, 1'b0, d, tag);
  endtask

  task automatic pop(input string tag);
    cyc(1'b0, 1'b0, 1'b1, '0, tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst         = 1'b1;
    bus.clr     = 1'b0;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-run with 5 entries, then across a write edge.
    for (int i = 0; i < 5; i++) push(Dw'($urandom), "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk({"async_rst", ".empty"}, 32'(bus.empty), 32'd1);
    chk({"async_rst", ".count"}, 32'(bus.count), 32'd0);
    chk({"async_rst", ".rd_data"}, 32'(bus.rd_data), 32'd0);
    bus.wr_req  = 1'b1;
    bus.wr_data = 16'h1234;
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    chk_all("rst_wr_edge");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clear with a coincident write stores nothing.
    for (int i = 0; i < 3; i++) push(Dw'($urandom), "pre_clr");
    cyc(1'b1, 1'b1, 1'b0, 16'h7777, "clr_wr");
    cyc(1'b0, 1'b0, 1'b0, '0, "after_clr");

    // Fill and drain in order.
    for (int i = 0; i < 8; i++) push(Dw'(16'h0011 + i), "fill");
    for (int i = 0; i < 8; i++) pop("drain");

    // Overflow: ninth write dropped, flag sticky until clr.
    for (int i = 0; i < 8; i++) push(Dw'($urandom), "ovf_fill");
    push(16'hBEEF, "ovf_write");
    pop("ovf_sticky_pop");
    cyc(1'b0, 1'b0, 1'b0, '0, "ovf_sticky_idle");
    cyc(1'b1, 1'b0, 1'b0, '0, "ovf_clr");

    // Simultaneous read/write while full.
    for (int i = 0; i < 8; i++) push(Dw'(16'h0100 + i), "rw_fill");
    cyc(1'b0, 1'b1, 1'b1, 16'h00AA, "rw_full");
    for (int i = 0; i < 8; i++) pop("rw_drain");

    // Read while empty with a coincident write.
    cyc(1'b0, 1'b1, 1'b1, 16'h0042, "unf_wr");
    cyc(1'b1, 1'b0, 1'b0, '0, "unf_clr");

    // Pointer wrap: 5 in, 5 out, 6 in, 6 out.
    for (int i = 0; i < 5; i++) push(Dw'($urandom), "wrap_w1");
    for (int i = 0; i < 5; i++) pop("wrap_r1");
    for (int i = 0; i < 6; i++) push(Dw'(16'h0200 + i), "wrap_w2");
    for (int i = 0; i < 6; i++) pop("wrap_r2");

    // Controller-style run: 4 results written, then 4 Read pulses with Wait gaps.
    for (int i = 0; i < 4; i++) begin
      push(Dw'($urandom), "ctl_write");
      cyc(1'b0, 1'b0, 1'b0, '0, "ctl_calc");
    end
    for (int i = 0; i < 4; i++) begin
      pop("ctl_read");
      cyc(1'b0, 1'b0, 1'b0, '0, "ctl_wait");
    end

    // Random traffic, occasional clear.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < 55),
          ($urandom_range(0, 99) < 45), Dw'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
